// File: rtl/id_ex_operand_stage_if.sv
// Decode-to-ID/EX bus: one decoded instruction with its regfile reads, under a valid/ready handshake.
interface id_ex_operand_stage_if #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [REG_AW-1:0] in_rs1_addr;
  logic [REG_AW-1:0] in_rs2_addr;
  logic [WIDTH-1:0]  in_rs1_data;
  logic [WIDTH-1:0]  in_rs2_data;
  logic [WIDTH-1:0]  in_imm;
  logic [WIDTH-1:0]  in_pc;
  logic              in_src_a_pc;
  logic              in_src_b_imm;
  logic [3:0]        in_alu_control;
  logic [REG_AW-1:0] in_rd_addr;
  logic              in_reg_write;

  modport master (
    output in_valid, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data, in_imm, in_pc,
           in_src_a_pc, in_src_b_imm, in_alu_control, in_rd_addr, in_reg_write,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data, in_imm, in_pc,
           in_src_a_pc, in_src_b_imm, in_alu_control, in_rd_addr, in_reg_write,
    output in_ready
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: captures one decoded instruction, forwards operands from EX/MEM and MEM/WB,
// tracks load-use hazards and presents registered ALU operands under a valid/ready handshake.
module id_ex_operand_stage #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  id_ex_operand_stage_if.slave dec,
  input  logic              exm_valid,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [WIDTH-1:0]  exm_data,
  input  logic              exm_is_load,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [WIDTH-1:0]  wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [WIDTH-1:0]  store_data,
  output logic [3:0]        alu_control,
  output logic [REG_AW-1:0] rd_addr,
  output logic              reg_write
);

  localparam logic [REG_AW-1:0] X0 = {REG_AW{1'b0}};

  // Capture priority: a non-load in EX/MEM is newest, then the writeback, then the regfile.
  function automatic logic [WIDTH-1:0] capture_operand(
    input logic [REG_AW-1:0] addr,  input logic [WIDTH-1:0] rf,
    input logic ev, input logic eld, input logic [REG_AW-1:0] erd, input logic [WIDTH-1:0] ed,
    input logic wv, input logic [REG_AW-1:0] wrd, input logic [WIDTH-1:0] wd
  );
    if (addr == X0)                          return {WIDTH{1'b0}};
    else if (ev && !eld && (erd == addr))    return ed;
    else if (wv && (wrd == addr))            return wd;
    else                                     return rf;
  endfunction

  // While held, the writeback completing the awaited load takes precedence over EX/MEM.
  function automatic logic [WIDTH-1:0] refresh_operand(
    input logic [REG_AW-1:0] addr,  input logic [WIDTH-1:0] cur,
    input logic ev, input logic eld, input logic [REG_AW-1:0] erd, input logic [WIDTH-1:0] ed,
    input logic wv, input logic [REG_AW-1:0] wrd, input logic [WIDTH-1:0] wd
  );
    if (addr == X0)                          return cur;
    else if (wv && (wrd == addr))            return wd;
    else if (ev && !eld && (erd == addr))    return ed;
    else                                     return cur;
  endfunction

  logic              valid_r, pend1_r, pend2_r;
  logic [REG_AW-1:0] rs1_addr_r, rs2_addr_r;
  logic              src_a_pc_r, src_b_imm_r;
  logic [WIDTH-1:0]  alu_a_r, alu_b_r, store_data_r;
  logic [3:0]        alu_control_r;
  logic [REG_AW-1:0] rd_addr_r;
  logic              reg_write_r;

  logic              out_valid_s, in_ready_s, transfer_s, accept_s;
  logic [WIDTH-1:0]  cap_rs1_s, cap_rs2_s, held_rs1_s, held_rs2_s;
  logic              cap_pend1_s, cap_pend2_s, wb_hit1_s, wb_hit2_s;

  // Handshake: a pending operand only blocks when it is actually consumed.
  always_comb begin
    out_valid_s = valid_r & ~(pend2_r | (pend1_r & ~src_a_pc_r));
    transfer_s  = out_valid_s & out_ready;
    in_ready_s  = ~valid_r | transfer_s;
    accept_s    = dec.in_valid & in_ready_s;
  end

  // Operand selection for capture and for refreshing the held entry.
  always_comb begin
    cap_rs1_s   = capture_operand(dec.in_rs1_addr, dec.in_rs1_data, exm_valid, exm_is_load,
                                  exm_rd, exm_data, wb_valid, wb_rd, wb_data);
    cap_rs2_s   = capture_operand(dec.in_rs2_addr, dec.in_rs2_data, exm_valid, exm_is_load,
                                  exm_rd, exm_data, wb_valid, wb_rd, wb_data);
    cap_pend1_s = exm_valid & exm_is_load & (exm_rd == dec.in_rs1_addr) & (dec.in_rs1_addr != X0);
    cap_pend2_s = exm_valid & exm_is_load & (exm_rd == dec.in_rs2_addr) & (dec.in_rs2_addr != X0);
    held_rs1_s  = refresh_operand(rs1_addr_r, alu_a_r, exm_valid, exm_is_load,
                                  exm_rd, exm_data, wb_valid, wb_rd, wb_data);
    held_rs2_s  = refresh_operand(rs2_addr_r, store_data_r, exm_valid, exm_is_load,
                                  exm_rd, exm_data, wb_valid, wb_rd, wb_data);
    wb_hit1_s   = wb_valid & (wb_rd == rs1_addr_r) & (rs1_addr_r != X0);
    wb_hit2_s   = wb_valid & (wb_rd == rs2_addr_r) & (rs2_addr_r != X0);
  end

  // Entry register: flush beats capture, capture beats hold/refresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r       <= 1'b0;
      pend1_r       <= 1'b0;
      pend2_r       <= 1'b0;
      rs1_addr_r    <= X0;
      rs2_addr_r    <= X0;
      src_a_pc_r    <= 1'b0;
      src_b_imm_r   <= 1'b0;
      alu_a_r       <= {WIDTH{1'b0}};
      alu_b_r       <= {WIDTH{1'b0}};
      store_data_r  <= {WIDTH{1'b0}};
      alu_control_r <= 4'b0000;
      rd_addr_r     <= X0;
      reg_write_r   <= 1'b0;
    end else if (flush) begin
      valid_r <= 1'b0;
      pend1_r <= 1'b0;
      pend2_r <= 1'b0;
    end else if (accept_s) begin
      valid_r       <= 1'b1;
      pend1_r       <= cap_pend1_s;
      pend2_r       <= cap_pend2_s;
      rs1_addr_r    <= dec.in_rs1_addr;
      rs2_addr_r    <= dec.in_rs2_addr;
      src_a_pc_r    <= dec.in_src_a_pc;
      src_b_imm_r   <= dec.in_src_b_imm;
      alu_a_r       <= dec.in_src_a_pc ? dec.in_pc : cap_rs1_s;
      alu_b_r       <= dec.in_src_b_imm ? dec.in_imm : cap_rs2_s;
      store_data_r  <= cap_rs2_s;
      alu_control_r <= dec.in_alu_control;
      rd_addr_r     <= dec.in_rd_addr;
      reg_write_r   <= dec.in_reg_write;
    end else if (valid_r) begin
      valid_r      <= ~transfer_s;
      pend1_r      <= pend1_r & ~wb_hit1_s;
      pend2_r      <= pend2_r & ~wb_hit2_s;
      alu_a_r      <= src_a_pc_r ? alu_a_r : held_rs1_s;
      alu_b_r      <= src_b_imm_r ? alu_b_r : held_rs2_s;
      store_data_r <= held_rs2_s;
    end
  end

  assign out_valid    = out_valid_s;
  assign dec.in_ready = in_ready_s;
  assign alu_a        = alu_a_r;
  assign alu_b        = alu_b_r;
  assign store_data   = store_data_r;
  assign alu_control  = alu_control_r;
  assign rd_addr      = rd_addr_r;
  assign reg_write    = reg_write_r;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed scenarios plus randomized traffic against an
// instruction-level reference model of the held entry.
module tb_id_ex_operand_stage;
  localparam int W  = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst, flush;
  logic exm_valid, exm_is_load, wb_valid, out_ready, out_valid, reg_write;
  logic [AW-1:0] exm_rd, wb_rd, rd_addr;
  logic [W-1:0]  exm_data, wb_data, alu_a, alu_b, store_data;
  logic [3:0]    alu_control;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage_if #(.WIDTH(W), .REG_AW(AW)) dec ();

  id_ex_operand_stage #(.WIDTH(W), .REG_AW(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .dec(dec),
    .exm_valid(exm_valid), .exm_rd(exm_rd), .exm_data(exm_data), .exm_is_load(exm_is_load),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .store_data(store_data),
    .alu_control(alu_control), .rd_addr(rd_addr), .reg_write(reg_write)
  );

  // Reference model: the one instruction the stage is holding.
  logic          m_valid, m_pend1, m_pend2, m_sa, m_sb, m_rw;
  logic [AW-1:0] m_rs1a, m_rs2a, m_rd;
  logic [W-1:0]  m_rs1, m_rs2, m_pc, m_imm;
  logic [3:0]    m_ctl;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_out_valid();
    return m_valid & ~(m_pend2 | (m_pend1 & ~m_sa));
  endfunction

  function automatic logic m_in_ready();
    return ~m_valid | (m_out_valid() & out_ready);
  endfunction

  function automatic logic [W-1:0] m_fwd(input logic [AW-1:0] a, input logic [W-1:0] rf);
    if (a == 0) return 0;
    if (exm_valid && !exm_is_load && exm_rd == a) return exm_data;
    if (wb_valid && wb_rd == a) return wb_data;
    return rf;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_pend1 = 0; m_pend2 = 0; m_sa = 0; m_sb = 0; m_rw = 0;
    m_rs1a = 0; m_rs2a = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_pc = 0; m_imm = 0; m_ctl = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    logic acc, xfer;
    acc  = dec.in_valid & m_in_ready();
    xfer = m_out_valid() & out_ready;
    if (rst) model_reset();
    else if (flush) begin
      m_valid = 0; m_pend1 = 0; m_pend2 = 0;
    end else if (acc) begin
      m_valid = 1;
      m_rs1a = dec.in_rs1_addr; m_rs2a = dec.in_rs2_addr;
      m_rs1 = m_fwd(dec.in_rs1_addr, dec.in_rs1_data);
      m_rs2 = m_fwd(dec.in_rs2_addr, dec.in_rs2_data);
      m_pend1 = exm_valid && exm_is_load && exm_rd == m_rs1a && m_rs1a != 0;
      m_pend2 = exm_valid && exm_is_load && exm_rd == m_rs2a && m_rs2a != 0;
      m_pc = dec.in_pc; m_imm = dec.in_imm; m_sa = dec.in_src_a_pc; m_sb = dec.in_src_b_imm;
      m_ctl = dec.in_alu_control; m_rd = dec.in_rd_addr; m_rw = dec.in_reg_write;
    end else if (m_valid) begin
      if (xfer) m_valid = 0;
      if (m_rs1a != 0 && wb_valid && wb_rd == m_rs1a) begin m_rs1 = wb_data; m_pend1 = 0; end
      else if (m_rs1a != 0 && exm_valid && !exm_is_load && exm_rd == m_rs1a) m_rs1 = exm_data;
      if (m_rs2a != 0 && wb_valid && wb_rd == m_rs2a) begin m_rs2 = wb_data; m_pend2 = 0; end
      else if (m_rs2a != 0 && exm_valid && !exm_is_load && exm_rd == m_rs2a) m_rs2 = exm_data;
    end
  endtask

  task automatic compare_outputs();
    check_eq("in_ready", 32'(dec.in_ready), 32'(m_in_ready()));
    check_eq("out_valid", 32'(out_valid), 32'(m_out_valid()));
    if (m_out_valid()) begin
      check_eq("alu_a", alu_a, m_sa ? m_pc : m_rs1);
      check_eq("alu_b", alu_b, m_sb ? m_imm : m_rs2);
      check_eq("store_data", store_data, m_rs2);
      check_eq("alu_control", 32'(alu_control), 32'(m_ctl));
      check_eq("rd_addr", 32'(rd_addr), 32'(m_rd));
      check_eq("reg_write", 32'(reg_write), 32'(m_rw));
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive_idle();
    dec.in_valid = 0; flush = 0; out_ready = 1;
    exm_valid = 0; exm_is_load = 0; exm_rd = 0; exm_data = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic drive_instr(input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                             input logic [W-1:0] d1, input logic [W-1:0] d2,
                             input logic sa, input logic sb, input logic [W-1:0] imm,
                             input logic [3:0] ctl);
    dec.in_valid = 1; dec.in_rs1_addr = r1; dec.in_rs2_addr = r2;
    dec.in_rs1_data = d1; dec.in_rs2_data = d2; dec.in_src_a_pc = sa; dec.in_src_b_imm = sb;
    dec.in_imm = imm; dec.in_pc = 32'h0000_1000; dec.in_alu_control = ctl;
    dec.in_rd_addr = 5'd3; dec.in_reg_write = 1;
  endtask

  initial begin
    rst = 1;
    drive_idle();
    drive_instr(5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 4'd0);
    dec.in_valid = 0;
    model_reset();
    #12;
    check_eq("rst_in_ready", 32'(dec.in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_alu_a", alu_a, 32'd0);
    check_eq("rst_store", store_data, 32'd0);
    @(posedge clk); #1;
    rst = 0;

    // 1: plain ADD from the regfile
    drive_instr(5'd1, 5'd2, 32'd5, 32'd7, 1'b0, 1'b0, 32'd0, 4'b0000);
    step();
    drive_idle();
    check_eq("t1_valid", 32'(out_valid), 32'd1);
    check_eq("t1_a", alu_a, 32'd5);
    check_eq("t1_b", alu_b, 32'd7);
    check_eq("t1_ctl", 32'(alu_control), 32'd0);
    step();

    // 2: EX/MEM forwarding wins over MEM/WB
    drive_instr(5'd1, 5'd2, 32'h999, 32'd7, 1'b0, 1'b0, 32'd0, 4'd0);
    exm_valid = 1; exm_rd = 5'd1; exm_data = 32'h100;
    wb_valid = 1; wb_rd = 5'd1; wb_data = 32'h200;
    step();
    drive_idle();
    check_eq("t2_a", alu_a, 32'h100);
    step();

    // 3: load-use on rs2, resolved by a later writeback
    drive_instr(5'd1, 5'd2, 32'd1, 32'd9, 1'b0, 1'b0, 32'd0, 4'd0);
    exm_valid = 1; exm_is_load = 1; exm_rd = 5'd2; exm_data = 32'hDEAD;
    step();
    drive_idle();
    check_eq("t3_wait0", 32'(out_valid), 32'd0);
    step();
    check_eq("t3_wait1", 32'(out_valid), 32'd0);
    wb_valid = 1; wb_rd = 5'd2; wb_data = 32'h55;
    step();
    drive_idle();
    check_eq("t3_valid", 32'(out_valid), 32'd1);
    check_eq("t3_b", alu_b, 32'h55);
    check_eq("t3_store", store_data, 32'h55);
    step();

    // 4: downstream stall, then back-to-back transfers
    drive_instr(5'd1, 5'd2, 32'hA, 32'hB, 1'b0, 1'b0, 32'd0, 4'd1);
    out_ready = 0;
    step();
    drive_instr(5'd1, 5'd2, 32'hC, 32'hD, 1'b0, 1'b0, 32'd0, 4'd2);
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      check_eq("t4_stall_ready", 32'(dec.in_ready), 32'd0);
      check_eq("t4_stall_a", alu_a, 32'hA);
      step();
    end
    out_ready = 1;
    step();
    check_eq("t4_b2b_valid", 32'(out_valid), 32'd1);
    check_eq("t4_b2b_a", alu_a, 32'hC);
    drive_instr(5'd1, 5'd2, 32'hE, 32'hF, 1'b0, 1'b0, 32'd0, 4'd3);
    step();
    check_eq("t4_b2b2_valid", 32'(out_valid), 32'd1);
    check_eq("t4_b2b2_a", alu_a, 32'hE);
    drive_idle();
    step();

    // 5: x0 is never forwarded; immediate path
    drive_instr(5'd0, 5'd2, 32'h1234, 32'd1, 1'b0, 1'b1, 32'hFFFF_FFFC, 4'd0);
    exm_valid = 1; exm_rd = 5'd0; exm_data = 32'hFFFF;
    step();
    drive_idle();
    check_eq("t5_a", alu_a, 32'd0);
    check_eq("t5_b", alu_b, 32'hFFFF_FFFC);
    step();

    // 6: flush during WAIT, then async reset mid-stall
    drive_instr(5'd2, 5'd1, 32'd1, 32'd2, 1'b0, 1'b0, 32'd0, 4'd0);
    exm_valid = 1; exm_is_load = 1; exm_rd = 5'd2;
    step();
    drive_idle();
    flush = 1;
    step();
    flush = 0;
    check_eq("t6_flush_valid", 32'(out_valid), 32'd0);
    check_eq("t6_flush_ready", 32'(dec.in_ready), 32'd1);
    drive_instr(5'd1, 5'd2, 32'h11, 32'h22, 1'b0, 1'b0, 32'd0, 4'd0);
    out_ready = 0;
    step();
    drive_idle();
    out_ready = 0;
    step();
    #2 rst = 1;
    #1;
    check_eq("t6_rst_valid", 32'(out_valid), 32'd0);
    check_eq("t6_rst_ready", 32'(dec.in_ready), 32'd1);
    model_reset();
    @(posedge clk); #1;
    rst = 0;

    // Randomized traffic over a small register window to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      dec.in_valid       = ($urandom_range(0, 9) < 7);
      dec.in_rs1_addr    = 5'($urandom_range(0, 3));
      dec.in_rs2_addr    = 5'($urandom_range(0, 3));
      dec.in_rs1_data    = $urandom;
      dec.in_rs2_data    = $urandom;
      dec.in_imm         = $urandom;
      dec.in_pc          = $urandom;
      dec.in_src_a_pc    = 1'($urandom_range(0, 1));
      dec.in_src_b_imm   = 1'($urandom_range(0, 1));
      dec.in_alu_control = 4'($urandom_range(0, 9));
      dec.in_rd_addr     = 5'($urandom_range(0, 31));
      dec.in_reg_write   = 1'($urandom_range(0, 1));
      exm_valid          = 1'($urandom_range(0, 1));
      exm_is_load        = ($urandom_range(0, 9) < 3);
      exm_rd             = 5'($urandom_range(0, 3));
      exm_data           = $urandom;
      wb_valid           = ($urandom_range(0, 9) < 4);
      wb_rd              = 5'($urandom_range(0, 3));
      wb_data            = $urandom;
      out_ready          = ($urandom_range(0, 9) < 7);
      flush              = ($urandom_range(0, 99) < 3);
      rst                = ($urandom_range(0, 499) == 0);
      if (rst) model_reset();
      step();
    end
    rst = 0;
    drive_idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
